// File: rtl/audio_level_meter.sv
// audio_level_meter: pops stereo words from the audio FIFO and publishes per-window
// decaying peak-hold bar levels and clip flags for the VGA bar renderer.
module audio_level_meter #(
  parameter int WINDOW  = 256,
  parameter int LEVEL_W = 8,
  parameter int DECAY   = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [31:0]        fifo_q,
  input  logic               fifo_rdempty,
  output logic               fifo_rdreq,
  output logic [LEVEL_W-1:0] level_l,
  output logic [LEVEL_W-1:0] level_r,
  output logic               clip_l,
  output logic               clip_r,
  output logic               level_valid,
  output logic [15:0]        frame_count
);
  localparam int CW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  typedef enum logic [1:0] {IDLE, REQ, CAP, PUB} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [14:0] pk_l_q, pk_r_q, mag_l, mag_r;
  logic win_clip_l_q, win_clip_r_q;
  logic [LEVEL_W-1:0] level_l_q, level_r_q;
  logic clip_l_q, clip_r_q, valid_q;
  logic [15:0] frame_q;
  logic last;
  // -32768 has no positive 16-bit twin, so it saturates to full scale
  function automatic logic [14:0] mag(input logic [15:0] x);
    logic [15:0] a;
    a = x[15] ? 16'(~x + 16'd1) : x;
    return a[15] ? 15'h7fff : a[14:0];
  endfunction
  function automatic logic [LEVEL_W-1:0] hold_next(input logic [LEVEL_W-1:0] nw,
                                                   input logic [LEVEL_W-1:0] hold);
    logic [LEVEL_W-1:0] dec;
    dec = (hold >= LEVEL_W'(DECAY)) ? hold - LEVEL_W'(DECAY) : '0;
    return (nw >= dec) ? nw : dec;
  endfunction
  assign mag_l = mag(fifo_q[31:16]);
  assign mag_r = mag(fifo_q[15:0]);
  assign last = cnt_q == CW'(WINDOW - 1);
  always_comb begin
    state_d = state_q == IDLE ? (fifo_rdempty ? IDLE : REQ) :
              state_q == REQ  ? CAP :
              state_q == CAP  ? (last ? PUB : IDLE) : IDLE;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      pk_l_q       <= '0;
      pk_r_q       <= '0;
      win_clip_l_q <= 1'b0;
      win_clip_r_q <= 1'b0;
      level_l_q    <= '0;
      level_r_q    <= '0;
      clip_l_q     <= 1'b0;
      clip_r_q     <= 1'b0;
      valid_q      <= 1'b0;
      frame_q      <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= state_q == PUB;
      if (state_q == CAP) begin
        pk_l_q       <= (mag_l > pk_l_q) ? mag_l : pk_l_q;
        pk_r_q       <= (mag_r > pk_r_q) ? mag_r : pk_r_q;
        win_clip_l_q <= win_clip_l_q | (mag_l == 15'h7fff);
        win_clip_r_q <= win_clip_r_q | (mag_r == 15'h7fff);
        cnt_q        <= cnt_q + 1'b1;
      end
      if (state_q == PUB) begin
        level_l_q    <= hold_next(pk_l_q[14 -: LEVEL_W], level_l_q);
        level_r_q    <= hold_next(pk_r_q[14 -: LEVEL_W], level_r_q);
        clip_l_q     <= win_clip_l_q;
        clip_r_q     <= win_clip_r_q;
        frame_q      <= frame_q + 16'd1;
        pk_l_q       <= '0;
        pk_r_q       <= '0;
        win_clip_l_q <= 1'b0;
        win_clip_r_q <= 1'b0;
        cnt_q        <= '0;
      end
    end
  end
  assign fifo_rdreq  = state_q == REQ;
  assign level_l     = level_l_q;
  assign level_r     = level_r_q;
  assign clip_l      = clip_l_q;
  assign clip_r      = clip_r_q;
  assign level_valid = valid_q;
  assign frame_count = frame_q;
endmodule
